// File: rtl/uart_tx_fifo_core_if.sv
// uart_tx_fifo_core_if
// Groups the configuration, push and status signals of the UART transmit channel.
//   master : bus wrapper side; drives config and push, observes status.
//   slave  : transmit core side.
// Signals:
//   tx_en, baud_div, data_bits, parity_mode, stop2 : frame configuration
//   wr_valid, wr_data, wr_ready                    : FIFO push handshake
//   ovf_clr, ovf                                   : sticky overflow flag and its clear
//   fifo_level, tx_busy, irq_idle                  : status
interface uart_tx_fifo_core_if #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             tx_en;
  logic [DIV_W-1:0] baud_div;
  logic [1:0]       data_bits;
  logic [1:0]       parity_mode;
  logic             stop2;
  logic             wr_valid;
  logic [7:0]       wr_data;
  logic             wr_ready;
  logic             ovf_clr;
  logic             ovf;
  logic [LVL_W-1:0] fifo_level;
  logic             tx_busy;
  logic             irq_idle;

  modport master (
    output tx_en, baud_div, data_bits, parity_mode, stop2, wr_valid, wr_data, ovf_clr,
    input  wr_ready, ovf, fifo_level, tx_busy, irq_idle
  );

  modport slave (
    input  tx_en, baud_div, data_bits, parity_mode, stop2, wr_valid, wr_data, ovf_clr,
    output wr_ready, ovf, fifo_level, tx_busy, irq_idle
  );
endinterface

// File: rtl/uart_tx_fifo_core.sv
// uart_tx_fifo_core
// Buffered UART transmitter: bytes are pushed into a FIFO and serialised with runtime-selected
// data length (5-8), parity (none/even/odd/mark) and one or two stop bits. Each frame latches
// its configuration when its byte is popped.
// Ports:
//   clk     : clock
//   rst     : asynchronous active-high reset; aborts any frame in progress
//   bus     : configuration / push / status bundle (slave side)
//   uart_tx : registered serial output, idle high
module uart_tx_fifo_core #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_tx_fifo_core_if.slave    bus,
  output logic                  uart_tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // FIFO storage and bookkeeping
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_ovf;

  // Frame state
  state_e           r_state;
  logic [DIV_W-1:0] r_baud_cnt;
  logic [DIV_W-1:0] r_div;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_idx;
  logic [2:0]       r_last_idx;
  logic             r_par_en;
  logic             r_par_bit;
  logic             r_stop2;
  logic             r_stop_idx;
  logic             r_tx;
  logic             r_busy;
  logic             r_irq;

  // Next-state values
  state_e           w_state_nxt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [DIV_W-1:0] w_div_nxt;
  logic [7:0]       w_shift_nxt;
  logic [2:0]       w_bit_idx_nxt;
  logic [2:0]       w_last_idx_nxt;
  logic             w_par_en_nxt;
  logic             w_par_bit_nxt;
  logic             w_stop2_nxt;
  logic             w_stop_idx_nxt;
  logic             w_tx_nxt;
  logic             w_busy_nxt;
  logic             w_irq_nxt;
  logic             w_start;

  logic             w_wr_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic [7:0]       w_head;
  logic [7:0]       w_mask;
  logic [7:0]       w_head_bits;
  logic             w_par_calc;
  logic             w_bit_end;
  logic [DIV_W-1:0] w_cnt_dec;

  // ---------------------------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------------------------
  // Readiness looks only at the registered level, so a same-cycle pop cannot admit a push.
  assign w_wr_ready = (r_level != FULL_LVL);
  assign w_push     = bus.wr_valid && w_wr_ready;
  assign w_pop      = w_start;
  assign w_empty    = (r_level == '0);
  assign w_head     = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (!w_push && w_pop) begin
        r_level <= r_level - LW'(1);
      end
      // A dropped push outranks a clear in the same cycle.
      if (bus.wr_valid && !w_wr_ready) begin
        r_ovf <= 1'b1;
      end else if (bus.ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Parity of the head word, computed over the selected data length only
  // ---------------------------------------------------------------------------------------------
  assign w_mask      = 8'hFF >> (2'd3 - bus.data_bits);
  assign w_head_bits = w_head & w_mask;

  always_comb begin
    w_par_calc = 1'b0;
    unique case (bus.parity_mode)
      2'b00: w_par_calc = 1'b0;
      2'b01: w_par_calc = ^w_head_bits;
      2'b10: w_par_calc = ~^w_head_bits;
      2'b11: w_par_calc = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------------------------
  assign w_bit_end = (r_baud_cnt == '0);
  assign w_cnt_dec = r_baud_cnt - DIV_W'(1);

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_baud_cnt;
    w_div_nxt      = r_div;
    w_shift_nxt    = r_shift;
    w_bit_idx_nxt  = r_bit_idx;
    w_last_idx_nxt = r_last_idx;
    w_par_en_nxt   = r_par_en;
    w_par_bit_nxt  = r_par_bit;
    w_stop2_nxt    = r_stop2;
    w_stop_idx_nxt = r_stop_idx;
    w_tx_nxt       = r_tx;
    w_busy_nxt     = r_busy;
    w_irq_nxt      = 1'b0;
    w_start        = 1'b0;

    case (r_state)
      StIdle: begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
        if (bus.tx_en && !w_empty) begin
          w_start = 1'b1;
        end
      end

      StStart: begin
        if (w_bit_end) begin
          w_state_nxt   = StData;
          w_cnt_nxt     = r_div;
          w_bit_idx_nxt = 3'd0;
          w_tx_nxt      = r_shift[0];
        end else begin
          w_cnt_nxt = w_cnt_dec;
        end
      end

      StData: begin
        if (w_bit_end) begin
          w_cnt_nxt = r_div;
          if (r_bit_idx == r_last_idx) begin
            if (r_par_en) begin
              w_state_nxt = StParity;
              w_tx_nxt    = r_par_bit;
            end else begin
              w_state_nxt    = StStop;
              w_tx_nxt       = 1'b1;
              w_stop_idx_nxt = 1'b0;
            end
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            w_shift_nxt   = r_shift >> 1;
            w_tx_nxt      = r_shift[1];
          end
        end else begin
          w_cnt_nxt = w_cnt_dec;
        end
      end

      StParity: begin
        if (w_bit_end) begin
          w_state_nxt    = StStop;
          w_cnt_nxt      = r_div;
          w_tx_nxt       = 1'b1;
          w_stop_idx_nxt = 1'b0;
        end else begin
          w_cnt_nxt = w_cnt_dec;
        end
      end

      StStop: begin
        if (w_bit_end) begin
          if (r_stop2 && !r_stop_idx) begin
            w_stop_idx_nxt = 1'b1;
            w_cnt_nxt      = r_div;
          end else if (bus.tx_en && !w_empty) begin
            // Back-to-back frame, no idle gap.
            w_start = 1'b1;
          end else begin
            w_state_nxt = StIdle;
            w_tx_nxt    = 1'b1;
            w_busy_nxt  = 1'b0;
            w_irq_nxt   = w_empty;
          end
        end else begin
          w_cnt_nxt = w_cnt_dec;
        end
      end

      default: begin
        w_state_nxt = StIdle;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase

    // Frame start pops the head and freezes the configuration for the whole frame.
    if (w_start) begin
      w_state_nxt    = StStart;
      w_cnt_nxt      = bus.baud_div;
      w_div_nxt      = bus.baud_div;
      w_shift_nxt    = w_head;
      w_last_idx_nxt = {1'b0, bus.data_bits} + 3'd4;
      w_par_en_nxt   = (bus.parity_mode != 2'b00);
      w_par_bit_nxt  = w_par_calc;
      w_stop2_nxt    = bus.stop2;
      w_stop_idx_nxt = 1'b0;
      w_tx_nxt       = 1'b0;
      w_busy_nxt     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_baud_cnt <= '0;
      r_div      <= '0;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_last_idx <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_idx <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_cnt_nxt;
      r_div      <= w_div_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_last_idx <= w_last_idx_nxt;
      r_par_en   <= w_par_en_nxt;
      r_par_bit  <= w_par_bit_nxt;
      r_stop2    <= w_stop2_nxt;
      r_stop_idx <= w_stop_idx_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= w_busy_nxt;
      r_irq      <= w_irq_nxt;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------------
  assign bus.wr_ready   = w_wr_ready;
  assign bus.ovf        = r_ovf;
  assign bus.fifo_level = r_level;
  assign bus.tx_busy    = r_busy;
  assign bus.irq_idle   = r_irq;
  assign uart_tx        = r_tx;

endmodule
